uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter (`uarttx`) between `N_REQ` byte producers. Each requester offers one frame through a valid/ready handshake. The arbiter grants one requester, loads the frame into the transmitter with a single-cycle enable, and waits for the transmitter's busy flag to rise and then fall before it grants again. It sits between the system's message sources and the `uarttx` instance.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `FRAME`, default 8: data frame width; must equal `uarttx` `FRAME`.
- `IDXW`, default `$clog2(N_REQ)`: width of the grant index; derived, not overridden.

- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `i_req_valid`, input, N_REQ: bit r high means requester r offers `i_req_data[r*FRAME +: FRAME]`.
- `i_req_data`, input, N_REQ*FRAME: packed requester frames.
- `o_req_ready`, output, N_REQ: one-hot, single-cycle pulse; the frame is consumed when valid and ready are both high.
- `o_tx_en`, output, 1: single-cycle load strobe to `uarttx` `i_en`.
- `o_tx_data`, output, FRAME: frame to `uarttx` `i_data`; valid while `o_tx_en` is high.
- `i_tx_busy`, input, 1: `uarttx` `o_busy`.
- `o_grant_idx`, output, IDXW: index of the current or last granted requester.
- `o_active`, output, 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `o_req_ready` = 0, `o_tx_en` = 0, `o_tx_data` = 0
  - `o_grant_idx` = 0, `o_active` = 0
  - round-robin pointer `last` = N_REQ-1, so requester 0 has first priority.
- **IDLE**
  - Grant only when `i_tx_busy` = 0 and `|i_req_valid` = 1.
  - The winner g is the first set valid bit searching from `last`+1 upward, wrapping N_REQ-1 → 0.
  - On the grant edge:
    - `o_req_ready[g]` <= 1
    - `o_tx_en` <= 1
    - `o_tx_data` <= data of requester g
    - `o_grant_idx` <= g
    - `last` <= g
    - next state = WAIT_ACK
- **WAIT_ACK**
  - `o_req_ready` and `o_tx_en` return to 0 on the first edge in this state.
  - Leave for WAIT_DONE on the first cycle `i_tx_busy` = 1.
- **WAIT_DONE**
  - Wait for `i_tx_busy` = 0.
  - Then go to IDLE, or to SEND_DATA if the data frame is still pending (tag mode only).
- **SEND_DATA** (tag mode only)
  - Pulse `o_tx_en` for one cycle with the latched data frame, then go to WAIT_ACK.
- A requester must hold valid and data stable until its ready pulse. Dropping valid before the grant is legal; that request is then not served.
- Valid bits that change while the state is not IDLE are ignored until the next IDLE evaluation.
- Reset mid-operation:
  - Reset forces IDLE and the reset values above. An in-flight frame is abandoned from the arbiter's side.
  - `uarttx` is not reset by this block. The arbiter issues no new grant until `i_tx_busy` is low.

## Timing
- Request latency: valid high at edge k with IDLE and `i_tx_busy` low gives ready and `o_tx_en` high during cycle k+1 (same cycle, exactly one cycle wide).
- `uarttx` asserts busy one cycle after sampling `i_en`, so WAIT_ACK normally lasts one cycle.
- Inter-frame gap: IDLE is re-entered one cycle after busy falls. The earliest next `o_tx_en` is the cycle after that.
- There is never more than one `o_tx_en` per busy period.
- A requester holding valid continuously is served at most once per round when other requesters are valid.

## Configuration
- `UART_ARB_TAG_EN`
  - **Defined:** each grant sends two frames.
    - First frame: the tag, i.e. g zero-extended to FRAME bits, driven on the grant edge.
    - Second frame: the requester's data, sent from SEND_DATA after the tag transmission completes.
    - The requester's data is latched internally on the grant edge; the ready pulse happens only once, at the grant.
    - `o_active` stays high across both frames.
  - **Undefined:** single-frame behaviour; the SEND_DATA state and the data latch are not built.

## Test plan
- Single request: only `i_req_valid` = 4'b0001, data 0xA5, tx idle → `o_req_ready` = 0001 and `o_tx_en` both high for one cycle with `o_tx_data` = 0xA5 and `o_grant_idx` = 0. After busy rises and falls, `o_active` returns to 0.
- Fairness: all four valid from reset with data 0x10..0x13 → `o_tx_data` sequence 0x10, 0x11, 0x12, 0x13. Each ready pulses exactly once.
- Rotation: requesters 1 and 2 held valid continuously → grants alternate 1, 2, 1, 2. There is no second `o_tx_en` inside any busy window.
- Busy blocking: `i_tx_busy` forced high, valid on requester 3 → no ready and no `o_tx_en` until busy is released. Grant to 3 occurs one cycle after release.
- Reset mid-frame: `i_rst` pulsed during WAIT_DONE → all outputs 0 on the next cycle. The next grant, with requesters 0 and 2 valid, goes to 0.
- Tag mode (`UART_ARB_TAG_EN` defined): requester 2 sends 0x3C → two `o_tx_en` pulses, with `o_tx_data` 0x02 then 0x3C. One ready pulse, `o_active` high throughout.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx between N_REQ valid/ready byte producers.
// Optional build macro UART_ARB_TAG_EN: each grant sends the requester index as a tag frame, then its data.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int FRAME = 8,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*FRAME-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_tx_en,
  output logic [FRAME-1:0]       o_tx_data,
  input  logic                   i_tx_busy,
  output logic [IDXW-1:0]        o_grant_idx,
  output logic                   o_active
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_SEND_DATA = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;
`endif

  state_t             state_r, state_s;
  logic [IDXW-1:0]    last_r, last_s;
  logic [N_REQ-1:0]   ready_r, ready_s;
  logic               tx_en_r, tx_en_s;
  logic [FRAME-1:0]   tx_data_r, tx_data_s;
  logic [IDXW-1:0]    grant_r, grant_s;
  logic               active_r;

  logic [FRAME-1:0]   req_frame_s [N_REQ];
  logic [IDXW-1:0]    cand_s;
  logic [IDXW-1:0]    win_idx_s;
  logic               win_found_s;
  logic [FRAME-1:0]   win_data_s;

`ifdef UART_ARB_TAG_EN
  logic [FRAME-1:0]   data_lat_r, data_lat_s;
  logic               data_pend_r, data_pend_s;
`endif

  // Round-robin winner search starting just after the last grant.
  always_comb begin
    cand_s      = {IDXW{1'b0}};
    win_idx_s   = {IDXW{1'b0}};
    win_found_s = |i_req_valid;
    for (int r = 0; r < N_REQ; r++) begin
      req_frame_s[r] = i_req_data[r*FRAME +: FRAME];
    end
    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s    = IDXW'((int'(last_r) + k) % N_REQ);
      win_idx_s = i_req_valid[cand_s] ? cand_s : win_idx_s;
    end
    win_data_s = req_frame_s[win_idx_s];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    ready_s   = {N_REQ{1'b0}};
    tx_en_s   = 1'b0;
    tx_data_s = tx_data_r;
    grant_s   = grant_r;
`ifdef UART_ARB_TAG_EN
    data_lat_s  = data_lat_r;
    data_pend_s = data_pend_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!i_tx_busy && win_found_s) begin
          ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
          tx_en_s = 1'b1;
          grant_s = win_idx_s;
          last_s  = win_idx_s;
          state_s = ST_WAIT_ACK;
`ifdef UART_ARB_TAG_EN
          tx_data_s   = FRAME'(win_idx_s);
          data_lat_s  = win_data_s;
          data_pend_s = 1'b1;
`else
          tx_data_s = win_data_s;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (i_tx_busy) begin
          state_s = ST_WAIT_DONE;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
`ifdef UART_ARB_TAG_EN
          if (data_pend_r) begin
            state_s     = ST_SEND_DATA;
            data_pend_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_SEND_DATA: begin
        tx_en_s   = 1'b1;
        tx_data_s = data_lat_r;
        state_s   = ST_WAIT_ACK;
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; the pointer resets so requester 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      last_r    <= IDXW'(N_REQ - 1);
      ready_r   <= {N_REQ{1'b0}};
      tx_en_r   <= 1'b0;
      tx_data_r <= {FRAME{1'b0}};
      grant_r   <= {IDXW{1'b0}};
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      last_r    <= last_s;
      ready_r   <= ready_s;
      tx_en_r   <= tx_en_s;
      tx_data_r <= tx_data_s;
      grant_r   <= grant_s;
      active_r  <= (state_s != ST_IDLE);
    end
  end

`ifdef UART_ARB_TAG_EN
  // Data frame held across the tag transmission.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_lat_r  <= {FRAME{1'b0}};
      data_pend_r <= 1'b0;
    end else begin
      data_lat_r  <= data_lat_s;
      data_pend_r <= data_pend_s;
    end
  end
`endif

  assign o_req_ready = ready_r;
  assign o_tx_en     = tx_en_r;
  assign o_tx_data   = tx_data_r;
  assign o_grant_idx = grant_r;
  assign o_active    = active_r;

endmodule
